// File: rtl/fetch_stage_pkg.sv
// ---------------------------------------------------------------------------
// fetch_stage_pkg
//   Shared definitions for the RV32I instruction-fetch stage.
//   - NOP encoding presented to the decoder when no instruction is valid.
//   - Instruction alignment (bytes between consecutive fetch addresses).
//   - Fetch FSM state encoding (2 bits): IDLE / REQ / HOLD / DISCARD.
// ---------------------------------------------------------------------------
package fetch_stage_pkg;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int unsigned INSTR_ALIGN = 4;

  localparam logic [1:0] ST_IDLE_ENC    = 2'd0;
  localparam logic [1:0] ST_REQ_ENC     = 2'd1;
  localparam logic [1:0] ST_HOLD_ENC    = 2'd2;
  localparam logic [1:0] ST_DISCARD_ENC = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = ST_IDLE_ENC,
    ST_REQ     = ST_REQ_ENC,
    ST_HOLD    = ST_HOLD_ENC,
    ST_DISCARD = ST_DISCARD_ENC
  } fs_state_e;

endpackage

// File: rtl/fetch_stage_buffer.sv
// ---------------------------------------------------------------------------
// fetch_buffer
//   1-entry {instr, pc} skid register used by fetch_stage to park a memory
//   response that arrives while the decoder is stalled.
// Ports
//   clk, rst         clock / async active-high reset (clears the full flag)
//   load             capture in_instr/in_pc, mark full
//   drain            entry consumed, mark empty
//   clear            flush: drop the entry (wins over load and drain)
//   in_instr, in_pc  data to capture
//   full             entry holds valid data
//   out_instr, out_pc  stored entry
// ---------------------------------------------------------------------------
module fetch_buffer #(
  parameter int PC_WIDTH = 32,
  parameter int IWIDTH   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                drain,
  input  logic                clear,
  input  logic [IWIDTH-1:0]   in_instr,
  input  logic [PC_WIDTH-1:0] in_pc,
  output logic                full,
  output logic [IWIDTH-1:0]   out_instr,
  output logic [PC_WIDTH-1:0] out_pc
);

  logic                full_q,  full_d;
  logic [IWIDTH-1:0]   instr_q, instr_d;
  logic [PC_WIDTH-1:0] pc_q,    pc_d;

  always_comb begin
    full_d  = full_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (clear) begin
      full_d = 1'b0;
    end else if (load) begin
      full_d  = 1'b1;
      instr_d = in_instr;
      pc_d    = in_pc;
    end else if (drain) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
    end else begin
      full_q <= full_d;
    end
  end

  // Payload is qualified by full_q, so it carries no reset.
  always_ff @(posedge clk) begin
    instr_q <= instr_d;
    pc_q    <= pc_d;
  end

  assign full      = full_q;
  assign out_instr = instr_q;
  assign out_pc    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   RV32I instruction-fetch stage feeding decoder_stage. Owns the PC, issues
//   one-outstanding req/ack reads to instruction memory and registers
//   {instr, pc, ce} for the decoder. Honours downstream stall and flush with
//   redirect; a 1-entry buffer absorbs a response landing during a stall.
//
// Parameters
//   PC_WIDTH  program-counter width
//   IWIDTH    instruction width
//   RESET_PC  first fetch address after reset (4-aligned)
//
// Ports
//   fs_clk, fs_rst      clock (rising edge), async reset (active-high)
//   fs_o_imem_addr      fetch address, stable while req is high
//   fs_o_imem_req       fetch request
//   fs_i_imem_ack       1-cycle response pulse (may coincide with req)
//   fs_i_imem_data      fetched instruction
//   fs_i_stall          downstream stall
//   fs_i_flush          redirect request
//   fs_i_flush_pc       redirect target
//   fs_o_instr, fs_o_pc instruction/pc to the decoder
//   fs_o_ce             fs_o_instr/fs_o_pc pair valid
//   fs_o_exception      misaligned redirect
//
// Build option
//   FS_MISALIGN_CHECK_EN  defined: a redirect with flush_pc[1:0]!=0 raises
//     fs_o_exception and halts fetching until the next aligned flush.
//     undefined: flush_pc[1:0] is forced to zero, fs_o_exception is 0.
// ---------------------------------------------------------------------------
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                  PC_WIDTH = 32,
  parameter int                  IWIDTH   = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                fs_clk,
  input  logic                fs_rst,
  output logic [PC_WIDTH-1:0] fs_o_imem_addr,
  output logic                fs_o_imem_req,
  input  logic                fs_i_imem_ack,
  input  logic [IWIDTH-1:0]   fs_i_imem_data,
  input  logic                fs_i_stall,
  input  logic                fs_i_flush,
  input  logic [PC_WIDTH-1:0] fs_i_flush_pc,
  output logic [IWIDTH-1:0]   fs_o_instr,
  output logic [PC_WIDTH-1:0] fs_o_pc,
  output logic                fs_o_ce,
  output logic                fs_o_exception
);

  function automatic logic [PC_WIDTH-1:0] pc_inc(input logic [PC_WIDTH-1:0] pc);
    // Modulo 2^PC_WIDTH: the top word wraps to 0 silently.
    return pc + PC_WIDTH'(INSTR_ALIGN);
  endfunction

  fs_state_e           state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q,    pc_d;
  logic [PC_WIDTH-1:0] tgt_q,   tgt_d;
  logic [IWIDTH-1:0]   instr_q, instr_d;
  logic [PC_WIDTH-1:0] opc_q,   opc_d;
  logic                ce_q,    ce_d;
  logic                exc_q,   exc_d;

  logic                buf_load, buf_drain, buf_clear, buf_full;
  logic [IWIDTH-1:0]   buf_instr;
  logic [PC_WIDTH-1:0] buf_pc;

  logic [PC_WIDTH-1:0] flush_pc_eff;
  logic                flush_misalign;
  logic                req;

`ifdef FS_MISALIGN_CHECK_EN
  assign flush_pc_eff   = fs_i_flush_pc;
  assign flush_misalign = |fs_i_flush_pc[1:0];
  assign fs_o_exception = exc_q;
`else
  assign flush_pc_eff   = fs_i_flush_pc & ~PC_WIDTH'(3);
  assign flush_misalign = 1'b0;
  assign fs_o_exception = 1'b0;
`endif

  // A raised exception parks the FSM in REQ with the request gated off.
  assign req = ((state_q == ST_REQ) || (state_q == ST_DISCARD)) && !exc_q;

  fetch_buffer #(
    .PC_WIDTH (PC_WIDTH),
    .IWIDTH   (IWIDTH)
  ) u_buf (
    .clk       (fs_clk),
    .rst       (fs_rst),
    .load      (buf_load),
    .drain     (buf_drain),
    .clear     (buf_clear),
    .in_instr  (fs_i_imem_data),
    .in_pc     (pc_q),
    .full      (buf_full),
    .out_instr (buf_instr),
    .out_pc    (buf_pc)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    tgt_d     = tgt_q;
    instr_d   = instr_q;
    opc_d     = opc_q;
    ce_d      = ce_q;
    exc_d     = exc_q;
    buf_load  = 1'b0;
    buf_drain = 1'b0;
    buf_clear = 1'b0;

    if (fs_i_flush) begin
      // Flush beats stall and any same-cycle response.
      ce_d      = 1'b0;
      instr_d   = IWIDTH'(NOP_INSTR);
      buf_clear = 1'b1;
      if (flush_misalign) begin
        exc_d   = 1'b1;
        state_d = ST_REQ;
      end else begin
        exc_d = 1'b0;
        if (req && !fs_i_imem_ack) begin
          // Memory cannot cancel: wait out the in-flight word, then redirect.
          tgt_d   = flush_pc_eff;
          state_d = ST_DISCARD;
        end else begin
          pc_d    = flush_pc_eff;
          state_d = ST_REQ;
        end
      end
    end else if (exc_q) begin
      ce_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_REQ;
          if (!fs_i_stall) ce_d = 1'b0;
        end
        ST_REQ: begin
          if (fs_i_imem_ack) begin
            if (!fs_i_stall && !buf_full) begin
              instr_d = fs_i_imem_data;
              opc_d   = pc_q;
              ce_d    = 1'b1;
              pc_d    = pc_inc(pc_q);
            end else begin
              // pc advances only when the parked word is handed on.
              buf_load = 1'b1;
              state_d  = ST_HOLD;
            end
          end else if (!fs_i_stall) begin
            ce_d = 1'b0;
          end
        end
        ST_HOLD: begin
          if (!fs_i_stall) begin
            instr_d   = buf_instr;
            opc_d     = buf_pc;
            ce_d      = 1'b1;
            pc_d      = pc_inc(pc_q);
            buf_drain = 1'b1;
            state_d   = ST_REQ;
          end
        end
        ST_DISCARD: begin
          if (!fs_i_stall) ce_d = 1'b0;
          if (fs_i_imem_ack) begin
            pc_d    = tgt_q;
            state_d = ST_REQ;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Fetch state / decoder output register boundary
  always_ff @(posedge fs_clk or posedge fs_rst) begin
    if (fs_rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      tgt_q   <= RESET_PC;
      instr_q <= IWIDTH'(NOP_INSTR);
      opc_q   <= '0;
      ce_q    <= 1'b0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      instr_q <= instr_d;
      opc_q   <= opc_d;
      ce_q    <= ce_d;
      exc_q   <= exc_d;
    end
  end

  assign fs_o_imem_addr = pc_q;
  assign fs_o_imem_req  = req;
  assign fs_o_instr     = instr_q;
  assign fs_o_pc        = opc_q;
  assign fs_o_ce        = ce_q;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//   Directed scenarios followed by a randomized phase for fetch_stage.
//   Instruction memory is a function of address with a programmable response
//   delay; the reference model tracks the expected next pc of the program
//   stream and the hold/flush rules of the decoder-facing outputs.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic        o_ce;
  logic        o_exc;

  int          total = 0;
  int          bad = 0;
  int          presented = 0;
  logic [31:0] exp_pc = '0;
  logic [31:0] special_addr = 32'hFFFF_FFFF;
  logic [31:0] special_data = '0;
  int          mem_delay = 0;
  bit          mem_rand = 1'b0;
  int          rnd_delay = 0;
  int          wait_cnt = 0;

  always #5 clk = ~clk;

  fetch_stage #(
    .PC_WIDTH (32),
    .IWIDTH   (32),
    .RESET_PC (32'h0)
  ) dut (
    .fs_clk         (clk),
    .fs_rst         (rst),
    .fs_o_imem_addr (imem_addr),
    .fs_o_imem_req  (imem_req),
    .fs_i_imem_ack  (imem_ack),
    .fs_i_imem_data (imem_data),
    .fs_i_stall     (stall),
    .fs_i_flush     (flush),
    .fs_i_flush_pc  (flush_pc),
    .fs_o_instr     (o_instr),
    .fs_o_pc        (o_pc),
    .fs_o_ce        (o_ce),
    .fs_o_exception (o_exc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == special_addr) return special_data;
    return ((a + 32'h0000_1000) * 32'h9E37_79B1) ^ 32'h00A5_0000;
  endfunction

  // Memory responder: acks a request after the chosen number of wait cycles.
  always @(negedge clk) begin
    if (rst) begin
      imem_ack = 1'b0;
      wait_cnt = 0;
    end else begin
      imem_ack = 1'b0;
      if (imem_req) begin
        if (wait_cnt >= (mem_rand ? rnd_delay : mem_delay)) begin
          imem_ack  = 1'b1;
          imem_data = mem_word(imem_addr);
          wait_cnt  = 0;
          rnd_delay = $urandom_range(0, 3);
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock; applies the output rules to whatever happened at the edge.
  task automatic step();
    logic        s, f, p_ce;
    logic [31:0] fpc, p_instr, p_pc;
    s = stall; f = flush; fpc = flush_pc;
    p_instr = o_instr; p_pc = o_pc; p_ce = o_ce;
    @(posedge clk);
    #1;
    if (f) begin
      chk("flush_ce", o_ce, 0);
      chk("flush_nop", o_instr, NOP);
      exp_pc = fpc & ~32'h3;
    end else if (s) begin
      chk("stall_instr", o_instr, p_instr);
      chk("stall_pc", o_pc, p_pc);
      chk("stall_ce", o_ce, p_ce);
    end else if (o_ce) begin
      chk("stream_pc", o_pc, exp_pc);
      chk("stream_instr", o_instr, mem_word(exp_pc));
      exp_pc += 4;
      presented++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    bit found;

    // Reset values
    #12;
    chk("rst_req", imem_req, 0);
    chk("rst_ce", o_ce, 0);
    chk("rst_instr", o_instr, NOP);
    chk("rst_pc", o_pc, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_exc", o_exc, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: back-to-back stream with a combinational memory
    step();
    chk("t1_req", imem_req, 1);
    chk("t1_addr", imem_addr, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t1_ce", o_ce, 1);
      chk("t1_pc", o_pc, 32'(i * 4));
    end

    // 2: response lands during a 3-cycle stall
    special_addr = exp_pc;
    special_data = 32'h0031_00B3;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_req_hold", imem_req, 0);
    end
    stall = 1'b0;
    step();
    chk("t2_instr", o_instr, 32'h0031_00B3);
    chk("t2_pc", o_pc, special_addr);
    chk("t2_ce", o_ce, 1);

    // 3: flush while a 2-cycle-delay request is in flight
    mem_delay = 2;
    step();
    chk("t3_gap_ce", o_ce, 0);
    flush = 1'b1; flush_pc = 32'h100;
    step();
    flush = 1'b0;
    chk("t3_req_held", imem_req, 1);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      step();
      if (o_ce) found = 1'b1;
      else chk("t3_gap_nop", o_instr, NOP);
    end
    chk("t3_found", found, 1);
    chk("t3_pc", o_pc, 32'h100);

    // 4: flush and stall together
    mem_delay = 0;
    step(); step();
    stall = 1'b1; flush = 1'b1; flush_pc = 32'h300;
    step();
    flush = 1'b0;
    chk("t4_ce", o_ce, 0);
    chk("t4_addr", imem_addr, 32'h300);
    step();
    stall = 1'b0;
    step();
    chk("t4_pc", o_pc, 32'h300);

    // 5: pc wrap
    flush = 1'b1; flush_pc = 32'hFFFF_FFFC;
    step();
    flush = 1'b0;
    chk("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
    step();
    chk("t5_pc_top", o_pc, 32'hFFFF_FFFC);
    chk("t5_addr_wrap", imem_addr, 0);
    step();
    chk("t5_pc_wrap", o_pc, 0);

    // 6: misaligned redirect
    flush = 1'b1; flush_pc = 32'h102;
    step();
    flush = 1'b0;
`ifdef FS_MISALIGN_CHECK_EN
    chk("t6_exc", o_exc, 1);
    chk("t6_req", imem_req, 0);
    step(); step();
    chk("t6_halt_ce", o_ce, 0);
    chk("t6_halt_req", imem_req, 0);
    flush = 1'b1; flush_pc = 32'h200;
    step();
    flush = 1'b0;
    chk("t6_exc_clr", o_exc, 0);
    chk("t6_addr", imem_addr, 32'h200);
    step();
    chk("t6_pc", o_pc, 32'h200);
`else
    chk("t6_addr", imem_addr, 32'h100);
    chk("t6_exc", o_exc, 0);
    step();
    chk("t6_pc", o_pc, 32'h100);
`endif

    // Randomized traffic
    mem_rand = 1'b1;
    p0 = presented;
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 19) == 0);
`ifdef FS_MISALIGN_CHECK_EN
      flush_pc = $urandom & 32'hFFFF_FFFC;
`else
      flush_pc = $urandom;
`endif
      step();
    end
    stall = 1'b0; flush = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("rand_progress", 32'((presented - p0) > 50), 1);

    // Reset in the middle of an outstanding request
    mem_rand = 1'b0; mem_delay = 3;
    step();
    rst = 1'b1;
    #1;
    chk("mid_rst_req", imem_req, 0);
    chk("mid_rst_ce", o_ce, 0);
    chk("mid_rst_instr", o_instr, NOP);
    chk("mid_rst_pc", o_pc, 0);
    chk("mid_rst_addr", imem_addr, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    mem_delay = 0;
    exp_pc = 32'h0;
    step(); step();
    chk("post_rst_ce", o_ce, 1);
    chk("post_rst_pc", o_pc, 0);
    step();
    chk("post_rst_pc4", o_pc, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
